// File: rtl/tms_io_pkg.sv
// Shared definitions for the front-panel K/R/O peripheral.
//   cap_state_t : O-capture FSM states (idle / settling / holding after write)
//   ref_state_t : display refresh FSM states (blank gap / digit lit)
//   seg_off     : segment drive value that turns every segment off
//   seg_drive   : applies the segment output polarity to a buffer value
package tms_io_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE   = 2'd0,
        CAP_SETTLE = 2'd1,
        CAP_HOLD   = 2'd2
    } cap_state_t;

    typedef enum logic {
        REF_BLANK = 1'b0,
        REF_SHOW  = 1'b1
    } ref_state_t;

    function automatic logic [7:0] seg_off(input bit active_low);
        return active_low ? 8'hff : 8'h00;
    endfunction

    function automatic logic [7:0] seg_drive(input logic [7:0] val, input bit active_low);
        return active_low ? ~val : val;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key of the front-panel matrix: two-flop synchroniser, 3-sample history
// taken on the shared sample tick, and a debounced level with hysteresis.
// Ports:
//   raw_clk in  system clock
//   reset   in  synchronous active-high reset
//   tick    in  one-cycle sample strobe shared by all keys
//   raw     in  raw switch level, 1 = pressed
//   deb     out debounced level
module key_debounce
    import tms_io_pkg::*;
(
    input  logic raw_clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic deb
);

    logic       sync1;
    logic       sync2;
    logic [2:0] hist;
    logic [2:0] hist_next;

    assign hist_next = {hist[1:0], sync2};

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 3'b000;
            deb   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (tick) begin
                hist <= hist_next;
                // Change state only after three agreeing samples; mixed histories hold.
                if (hist_next == 3'b111) begin
                    deb <= 1'b1;
                end else if (hist_next == 3'b000) begin
                    deb <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/tms_panel_io.sv
// Front-panel peripheral on the CPU K/R/O pins: scans a debounced key matrix
// against the R strobes, captures O segment data per strobed digit and
// refreshes a multiplexed LED display with blanking gaps.
// Ports:
//   raw_clk   in  system clock
//   reset     in  synchronous active-high reset
//   pins_r    in  [NUM_R]      R strobes from the CPU
//   pins_o    in  [8]          O segment data from the CPU
//   pins_k    out [4]          K nibble returned to the CPU (registered)
//   keys      in  [4*NUM_R]    raw switch levels, index r*4+k, 1 = pressed
//   key_any   out              any debounced key pressed (registered)
//   seg       out [8]          segment drive, polarity per SEG_ACTIVE_LOW
//   digit_sel out [NUM_DIGITS] one-hot digit enable, active-high
module tms_panel_io
    import tms_io_pkg::*;
#(
    parameter int NUM_R          = 11,
    parameter int NUM_DIGITS     = 8,
    parameter int SAMPLE_DIV     = 12000,
    parameter int SETTLE_CYCLES  = 16,
    parameter int REFRESH_CYCLES = 1500,
    parameter int BLANK_CYCLES   = 100,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  raw_clk,
    input  logic                  reset,
    input  logic [NUM_R-1:0]      pins_r,
    input  logic [7:0]            pins_o,
    output logic [3:0]            pins_k,
    input  logic [4*NUM_R-1:0]    keys,
    output logic                  key_any,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] digit_sel
);

    localparam bit ACT_LOW = (SEG_ACTIVE_LOW != 0);
    localparam int PRE_W   = $clog2(SAMPLE_DIV + 1);
    localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int REF_MAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int REF_W   = $clog2(REF_MAX + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // ---------------- key sampling ----------------
    logic [PRE_W-1:0]   presc;
    logic               tick;
    logic [4*NUM_R-1:0] deb;
    logic [3:0]         k_next;

    assign tick = (presc == PRE_W'(SAMPLE_DIV - 1));

    always_ff @(posedge raw_clk) begin
        if (reset || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < 4 * NUM_R; i++) begin : g_key
        key_debounce u_key (
            .raw_clk (raw_clk),
            .reset   (reset),
            .tick    (tick),
            .raw     (keys[i]),
            .deb     (deb[i])
        );
    end

    // Matrix read: every asserted R row contributes its four debounced keys.
    always_comb begin
        k_next = 4'b0000;
        for (int r = 0; r < NUM_R; r++) begin
            if (pins_r[r]) begin
                k_next = k_next | deb[r*4 +: 4];
            end
        end
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            pins_k  <= 4'b0000;
            key_any <= 1'b0;
        end else begin
            pins_k  <= k_next;
            key_any <= |deb;
        end
    end

    // ---------------- O capture ----------------
    cap_state_t       cap_state;
    cap_state_t       cap_next;
    logic [NUM_R-1:0] r_lat;
    logic [7:0]       o_lat;
    logic [SET_W-1:0] cap_cnt;
    logic [IDX_W-1:0] cap_idx;
    logic [IDX_W-1:0] strobe_idx;
    logic [7:0]       digit_buf [NUM_DIGITS];
    logic             strobe_ok;
    logic             changed;
    logic             settled;
    logic             cap_latch;
    logic             cap_write;

    // A strobe is capturable only when exactly one digit line is high and no
    // key-only R line is active alongside it.
    always_comb begin
        strobe_ok  = $onehot(pins_r[NUM_DIGITS-1:0]);
        strobe_idx = '0;
        for (int r = 0; r < NUM_DIGITS; r++) begin
            if (pins_r[r]) begin
                strobe_idx = IDX_W'(r);
            end
        end
        for (int r = NUM_DIGITS; r < NUM_R; r++) begin
            if (pins_r[r]) begin
                strobe_ok = 1'b0;
            end
        end
    end

    assign changed = (pins_r != r_lat) || (pins_o != o_lat);
    assign settled = (cap_cnt == SET_W'(SETTLE_CYCLES - 1));

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            cap_state <= CAP_IDLE;
        end else begin
            cap_state <= cap_next;
        end
    end

    always_comb begin
        cap_next = cap_state;
        case (cap_state)
            CAP_IDLE: begin
                if (strobe_ok) cap_next = CAP_SETTLE;
            end
            CAP_SETTLE: begin
                if (changed) begin
                    if (!strobe_ok) cap_next = CAP_IDLE;
                end else if (settled) begin
                    cap_next = CAP_HOLD;
                end
            end
            CAP_HOLD: begin
                if (changed) cap_next = CAP_IDLE;
            end
            default: cap_next = CAP_IDLE;
        endcase
    end

    always_comb begin
        cap_latch = ((cap_state == CAP_IDLE) && strobe_ok) ||
                    ((cap_state == CAP_SETTLE) && changed && strobe_ok);
        cap_write = (cap_state == CAP_SETTLE) && !changed && settled;
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            r_lat   <= '0;
            o_lat   <= '0;
            cap_cnt <= '0;
            cap_idx <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_buf[i] <= 8'h00;
            end
        end else begin
            if (cap_latch) begin
                r_lat   <= pins_r;
                o_lat   <= pins_o;
                cap_idx <= strobe_idx;
                cap_cnt <= '0;
            end else if (cap_state == CAP_SETTLE) begin
                cap_cnt <= cap_cnt + SET_W'(1);
            end
            if (cap_write) begin
                digit_buf[cap_idx] <= o_lat;
            end
        end
    end

    // ---------------- display refresh ----------------
    ref_state_t       ref_state;
    ref_state_t       ref_next;
    logic [REF_W-1:0] ref_cnt;
    logic [IDX_W-1:0] ref_idx;
    logic [7:0]       seg_lat;
    logic             blank_done;
    logic             show_done;

    assign blank_done = (ref_cnt == REF_W'(BLANK_CYCLES - 1));
    assign show_done  = (ref_cnt == REF_W'(REFRESH_CYCLES - 1));

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            ref_state <= REF_BLANK;
        end else begin
            ref_state <= ref_next;
        end
    end

    always_comb begin
        ref_next = ref_state;
        case (ref_state)
            REF_BLANK: if (blank_done) ref_next = REF_SHOW;
            REF_SHOW:  if (show_done)  ref_next = REF_BLANK;
            default:   ref_next = REF_BLANK;
        endcase
    end

    always_comb begin
        digit_sel = '0;
        seg       = seg_off(ACT_LOW);
        if (ref_state == REF_SHOW) begin
            digit_sel[ref_idx] = 1'b1;
            seg                = seg_lat;
        end
    end

    // The segment pattern is snapshotted on entry to SHOW, so a capture into
    // the digit currently lit only appears on its next turn.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            ref_cnt <= '0;
            ref_idx <= '0;
            seg_lat <= seg_off(ACT_LOW);
        end else begin
            if (ref_next != ref_state) begin
                ref_cnt <= '0;
            end else begin
                ref_cnt <= ref_cnt + REF_W'(1);
            end
            if ((ref_state == REF_BLANK) && blank_done) begin
                seg_lat <= seg_drive(digit_buf[ref_idx], ACT_LOW);
            end
            if ((ref_state == REF_SHOW) && show_done) begin
                ref_idx <= (ref_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : ref_idx + IDX_W'(1);
            end
        end
    end

endmodule
